// File: rtl/wshb_arb2.sv
// Two-master round-robin Wishbone arbiter. The grant changes only when the owner drops cyc.
// Optional arbitration statistics are enabled with `define WSHB_ARB_STATS_EN.
module wshb_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_dat_ms,
  output logic [DATA_W-1:0] m0_dat_sm,
  output logic              m0_ack,
  output logic              m0_rty,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_dat_ms,
  output logic [DATA_W-1:0] m1_dat_sm,
  output logic              m1_ack,
  output logic              m1_rty,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_dat_ms,
  input  logic [DATA_W-1:0] s_dat_sm,
  input  logic              s_ack,
  input  logic              s_rty
`ifdef WSHB_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       gnt_cnt0,
  output logic [31:0]       gnt_cnt1,
  output logic [31:0]       wait_cnt0,
  output logic [31:0]       wait_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == GNT0 && r_state != GNT0) r_last <= 1'b0;
      if (w_nextState == GNT1 && r_state != GNT1) r_last <= 1'b1;
    end
  end

  // The owner keeps the bus until it drops cyc; on a tie the master not granted last wins.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc && m1_cyc) w_nextState = r_last ? GNT0 : GNT1;
        else if (m0_cyc)      w_nextState = GNT0;
        else if (m1_cyc)      w_nextState = GNT1;
        else                  w_nextState = IDLE;
      end
      GNT0:    if (!m0_cyc) w_nextState = m1_cyc ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc) w_nextState = m0_cyc ? GNT0 : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    case (r_state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
      end
      default: ;
    endcase
  end

  // Read data is shared; only ack/rty are steered, so responses in IDLE are dropped.
  assign m0_ack    = s_ack & (r_state == GNT0);
  assign m1_ack    = s_ack & (r_state == GNT1);
  assign m0_rty    = s_rty & (r_state == GNT0);
  assign m1_rty    = s_rty & (r_state == GNT1);
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

`ifdef WSHB_ARB_STATS_EN
  logic [31:0] r_gntCnt0;
  logic [31:0] r_gntCnt1;
  logic [31:0] r_waitCnt0;
  logic [31:0] r_waitCnt1;

  // Saturating counters; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_gntCnt0  <= '0;
      r_gntCnt1  <= '0;
      r_waitCnt0 <= '0;
      r_waitCnt1 <= '0;
    end else begin
      if (w_nextState == GNT0 && r_state != GNT0 && r_gntCnt0 != '1)
        r_gntCnt0 <= r_gntCnt0 + 32'd1;
      if (w_nextState == GNT1 && r_state != GNT1 && r_gntCnt1 != '1)
        r_gntCnt1 <= r_gntCnt1 + 32'd1;
      if (m0_cyc && r_state != GNT0 && r_waitCnt0 != '1)
        r_waitCnt0 <= r_waitCnt0 + 32'd1;
      if (m1_cyc && r_state != GNT1 && r_waitCnt1 != '1)
        r_waitCnt1 <= r_waitCnt1 + 32'd1;
    end
  end

  assign gnt_cnt0  = r_gntCnt0;
  assign gnt_cnt1  = r_gntCnt1;
  assign wait_cnt0 = r_waitCnt0;
  assign wait_cnt1 = r_waitCnt1;
`endif

endmodule

// File: tb/tb_wshb_arb2.sv
// Scoreboard bench for wshb_arb2: directed scenarios then random traffic,
// checked against an ownership model of the round-robin arbitration rules.
module tb_wshb_arb2;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [1:0]  sel;
    logic [15:0] dms;
    logic [1:0]  ack;
    logic [1:0]  rty;
    logic [15:0] dsm;
  } expT;

  logic        clk;
  logic        rst;
  logic        mCyc [2];
  logic        mStb [2];
  logic        mWe  [2];
  logic [31:0] mAdr [2];
  logic [1:0]  mSel [2];
  logic [15:0] mDms [2];
  logic [15:0] m0DatSm, m1DatSm;
  logic        m0Ack, m1Ack, m0Rty, m1Rty;
  logic        sCyc, sStb, sWe;
  logic [31:0] sAdr;
  logic [1:0]  sSel;
  logic [15:0] sDatMs;
  logic [15:0] sDatSm;
  logic        sAck, sRty;

  logic        nRst;
  logic        nCyc [2];
  logic        nStb [2];
  logic        nWe  [2];
  logic [31:0] nAdr [2];
  logic [1:0]  nSel [2];
  logic [15:0] nDms [2];
  logic        nAck, nRty;
  logic [15:0] nDsm;

  int  ownerM;
  int  lastM;
  expT expQ [$];
  int  checks;
  int  fails;

`ifdef WSHB_ARB_STATS_EN
  logic        statsClr;
  logic [31:0] gntCnt0, gntCnt1, waitCnt0, waitCnt1;
  initial statsClr = 1'b0;
`endif

  wshb_arb2 dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mCyc[0]), .m0_stb(mStb[0]), .m0_we(mWe[0]), .m0_adr(mAdr[0]),
    .m0_sel(mSel[0]), .m0_dat_ms(mDms[0]), .m0_dat_sm(m0DatSm),
    .m0_ack(m0Ack), .m0_rty(m0Rty),
    .m1_cyc(mCyc[1]), .m1_stb(mStb[1]), .m1_we(mWe[1]), .m1_adr(mAdr[1]),
    .m1_sel(mSel[1]), .m1_dat_ms(mDms[1]), .m1_dat_sm(m1DatSm),
    .m1_ack(m1Ack), .m1_rty(m1Rty),
    .s_cyc(sCyc), .s_stb(sStb), .s_we(sWe), .s_adr(sAdr), .s_sel(sSel),
    .s_dat_ms(sDatMs), .s_dat_sm(sDatSm), .s_ack(sAck), .s_rty(sRty)
`ifdef WSHB_ARB_STATS_EN
    , .stats_clr(statsClr), .gnt_cnt0(gntCnt0), .gnt_cnt1(gntCnt1),
    .wait_cnt0(waitCnt0), .wait_cnt1(waitCnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Ownership model: a holder keeps the bus; otherwise the requester not granted last wins.
  task automatic updateModel();
    int pref;
    if (rst === 1'b1) begin
      ownerM = -1;
      lastM  = 1;
    end else if (!(ownerM >= 0 && mCyc[ownerM] === 1'b1)) begin
      pref = 1 - lastM;
      if (mCyc[pref] === 1'b1)          ownerM = pref;
      else if (mCyc[1-pref] === 1'b1)   ownerM = 1 - pref;
      else                              ownerM = -1;
      if (ownerM >= 0) lastM = ownerM;
    end
  endtask

  task automatic applyStimulus();
    expT e;
    @(posedge clk);
    updateModel();
    #1;
    rst = nRst;
    for (int k = 0; k < 2; k++) begin
      mCyc[k] = nCyc[k]; mStb[k] = nStb[k]; mWe[k] = nWe[k];
      mAdr[k] = nAdr[k]; mSel[k] = nSel[k]; mDms[k] = nDms[k];
    end
    sAck = nAck; sRty = nRty; sDatSm = nDsm;
    e = '0;
    if (ownerM >= 0) begin
      e.cyc = mCyc[ownerM]; e.stb = mStb[ownerM]; e.we = mWe[ownerM];
      e.adr = mAdr[ownerM]; e.sel = mSel[ownerM]; e.dms = mDms[ownerM];
      e.ack[ownerM] = sAck;
      e.rty[ownerM] = sRty;
    end
    e.dsm = sDatSm;
    expQ.push_back(e);
  endtask

  task automatic stageIdle();
    nRst = 1'b0; nAck = 1'b0; nRty = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nCyc[k] = 1'b0; nStb[k] = 1'b0; nWe[k] = 1'b0;
    end
  endtask

  task automatic stageReq(input int k, input logic we, input logic [31:0] adr, input logic [15:0] d);
    nCyc[k] = 1'b1; nStb[k] = 1'b1; nWe[k] = we;
    nAdr[k] = adr; nSel[k] = 2'b11; nDms[k] = d;
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("slaveReq", 64'({sCyc, sStb, sWe, sAdr, sSel, sDatMs}),
                    64'({e.cyc, e.stb, e.we, e.adr, e.sel, e.dms}));
        checkOutput("ackRty", 64'({m1Ack, m0Ack, m1Rty, m0Rty}), 64'({e.ack, e.rty}));
        checkOutput("datSm0", 64'(m0DatSm), 64'(e.dsm));
        checkOutput("datSm1", 64'(m1DatSm), 64'(e.dsm));
      end
    end
  end

  initial begin : stimulus
    checks = 0; fails = 0;
    ownerM = -1; lastM = 1;
    rst = 1'b1; sAck = 1'b0; sRty = 1'b0; sDatSm = '0;
    for (int k = 0; k < 2; k++) begin
      mCyc[k] = 1'b0; mStb[k] = 1'b0; mWe[k] = 1'b0;
      mAdr[k] = '0; mSel[k] = '0; mDms[k] = '0;
      nAdr[k] = '0; nSel[k] = '0; nDms[k] = '0;
    end
    nDsm = '0;
    stageIdle();
    nRst = 1'b1;
    repeat (2) applyStimulus();

    // Single m0 write, acked on the second cycle.
    stageIdle();
    stageReq(0, 1'b1, 32'h100, 16'hBEEF);
    applyStimulus();
    nAck = 1'b1;
    applyStimulus();
    stageIdle();
    repeat (2) applyStimulus();

    // Simultaneous requests straight out of reset, handover, then alternation.
    nRst = 1'b1;
    applyStimulus();
    stageIdle();
    stageReq(0, 1'b1, 32'h110, 16'h1111);
    stageReq(1, 1'b0, 32'h200, 16'h0000);
    repeat (3) applyStimulus();
    nCyc[0] = 1'b0; nStb[0] = 1'b0;
    repeat (3) applyStimulus();
    stageIdle();
    repeat (2) applyStimulus();
    stageReq(0, 1'b0, 32'h120, 16'h2222);
    stageReq(1, 1'b0, 32'h210, 16'h3333);
    repeat (3) applyStimulus();
    stageIdle();
    repeat (2) applyStimulus();

    // m1 burst of reads with m0 arriving mid-burst.
    stageReq(1, 1'b0, 32'h300, 16'h0);
    for (int beat = 0; beat < 10; beat++) begin
      nAck = (beat >= 1);
      nAdr[1] = 32'h300 + 32'(beat * 2);
      nDsm = 16'hA000 + 16'(beat);
      if (beat == 3) stageReq(0, 1'b1, 32'h400, 16'h5A5A);
      applyStimulus();
    end
    nCyc[1] = 1'b0; nStb[1] = 1'b0;
    repeat (3) applyStimulus();
    stageIdle();
    repeat (2) applyStimulus();

    // Retry on an m1 cycle, then an ack while idle.
    stageReq(1, 1'b0, 32'h500, 16'h0);
    applyStimulus();
    nRty = 1'b1;
    applyStimulus();
    nRty = 1'b0;
    applyStimulus();
    stageIdle();
    nAck = 1'b1; nDsm = 16'h1234;
    repeat (3) applyStimulus();

    // Reset in the middle of an m0 transfer, then both request.
    stageIdle();
    stageReq(0, 1'b1, 32'h600, 16'hCAFE);
    repeat (3) applyStimulus();
    nRst = 1'b1;
    applyStimulus();
    nRst = 1'b0;
    stageReq(1, 1'b0, 32'h700, 16'h0);
    repeat (3) applyStimulus();
    stageIdle();
    repeat (2) applyStimulus();

    // Random traffic with sticky cyc so ownership periods and contention occur.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(3) == 0) nCyc[k] = ~nCyc[k];
        nStb[k] = nCyc[k] & 1'($urandom_range(1));
        nWe[k]  = 1'($urandom_range(1));
        nAdr[k] = $urandom;
        nSel[k] = 2'($urandom_range(3));
        nDms[k] = 16'($urandom);
      end
      nAck = 1'($urandom_range(1));
      nRty = ($urandom_range(7) == 0);
      nDsm = 16'($urandom);
      nRst = ($urandom_range(63) == 0);
      applyStimulus();
    end

    stageIdle();
    applyStimulus();
    @(negedge clk);
    @(posedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
